// File: rtl/tdc_link_pkg.sv
// Shared constants and encodings for the 40-bit single-edge TDC data link.
package tdc_link_pkg;

   localparam logic [9:0]  K28_5      = 10'b0011111010;
   localparam logic [9:0]  D21_5      = 10'b1010101010;
   localparam logic [39:0] IDLE_WORD  = {K28_5, K28_5, K28_5, K28_5};
   localparam logic [39:0] TRAIN_WORD = {K28_5, D21_5, K28_5, D21_5};

   typedef enum logic [1:0] {
      WT_IDLE  = 2'd0,
      WT_DATA  = 2'd1,
      WT_TRAIN = 2'd2
   } word_type_e;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_TRAIN     = 2'd1,
      ST_DATA      = 2'd2
   } tx_state_e;

endpackage

// File: rtl/single_edge_data_slip_40b.sv
// Bit-offset injector: splices the previous and current word so the far-end
// realigner can be exercised with a known shift.
module single_edge_data_slip_40b
   import tdc_link_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [3:0]  slip_i,
   input  logic [39:0] w_i,
   output logic [39:0] word_o
);

   logic [39:0] p_q;
   logic [79:0] cat;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     p_q <= '0;
      else if (en_i) p_q <= w_i;
   end

   always_comb begin
      cat    = {p_q, w_i} << slip_i;
      word_o = cat[79:40];
      if (slip_i == 4'd0 || slip_i == 4'd15) word_o = w_i;
   end

endmodule

// File: rtl/single_edge_data_frame_tx_40b.sv
// Transmit framer: packs four 10-bit symbols per 40-bit word and emits train,
// data or idle words on each locked tick. Optional slip stage: TX_SLIP_EN.
module single_edge_data_frame_tx_40b
   import tdc_link_pkg::*;
#(
   parameter int TRAIN_WORDS = 64,
   parameter int IDLE_CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  locked,
   input  logic                  train_req,
   input  logic [9:0]            sym_in,
   input  logic                  sym_valid,
   output logic                  sym_ready,
`ifdef TX_SLIP_EN
   input  logic [3:0]            slip,
`endif
   output logic [39:0]           data_40b,
   output logic [1:0]            word_type,
   output logic [IDLE_CNT_W-1:0] idle_cnt
);

   localparam int TW_W = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

   tx_state_e             state_q, state_d;
   logic [TW_W-1:0]       trn_cnt_q, trn_cnt_d;
   logic [3:0][9:0]       slots_q, slots_d;
   logic [2:0]            cnt_q, cnt_d, base;
   logic [39:0]           data_q, w_sel, w_out;
   word_type_e            type_q, type_sel;
   logic [IDLE_CNT_W-1:0] idle_q, idle_d;
   logic                  ev, emit, accept;

   assign ev        = locked & tick;
   assign sym_ready = (state_q == ST_DATA) & ((cnt_q != 3'd4) | ev);
   assign accept    = sym_valid & sym_ready;

   always_comb begin
      state_d   = state_q;
      trn_cnt_d = trn_cnt_q;
      idle_d    = idle_q;
      emit      = 1'b0;
      w_sel     = IDLE_WORD;
      type_sel  = WT_IDLE;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (locked) begin
               state_d   = ST_TRAIN;
               trn_cnt_d = '0;
            end
         end
         ST_TRAIN: begin
            if (ev) begin
               emit     = 1'b1;
               w_sel    = TRAIN_WORD;
               type_sel = WT_TRAIN;
               if (trn_cnt_q == TW_W'(TRAIN_WORDS - 1)) state_d = ST_DATA;
               else trn_cnt_d = trn_cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (ev) begin
               emit = 1'b1;
               if (cnt_q == 3'd4) begin
                  w_sel    = slots_q;
                  type_sel = WT_DATA;
               end else if (idle_q != '1) begin
                  idle_d = idle_q + 1'b1;
               end
            end
            if (train_req) begin
               state_d   = ST_TRAIN;
               trn_cnt_d = '0;
            end
         end
         default: state_d = ST_WAIT_LOCK;
      endcase
      if (!locked) state_d = ST_WAIT_LOCK;
   end

   // Slot 0 sits at the top of the packed array so the word is slots_q as-is.
   always_comb begin
      slots_d = slots_q;
      base    = (state_q == ST_DATA && ev && cnt_q == 3'd4) ? 3'd0 : cnt_q;
      cnt_d   = base;
      if (accept) begin
         slots_d[2'd3 - base[1:0]] = sym_in;
         cnt_d                     = base + 3'd1;
      end
      if (!locked) cnt_d = 3'd0;
   end

`ifdef TX_SLIP_EN
   single_edge_data_slip_40b u_slip (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (emit),
      .slip_i (slip),
      .w_i    (w_sel),
      .word_o (w_out)
   );
`else
   assign w_out = w_sel;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_WAIT_LOCK;
         trn_cnt_q <= '0;
         slots_q   <= '0;
         cnt_q     <= 3'd0;
         data_q    <= '0;
         type_q    <= WT_IDLE;
         idle_q    <= '0;
      end else begin
         state_q   <= state_d;
         trn_cnt_q <= trn_cnt_d;
         slots_q   <= slots_d;
         cnt_q     <= cnt_d;
         idle_q    <= idle_d;
         if (emit) begin
            data_q <= w_out;
            type_q <= type_sel;
         end
      end
   end

   assign data_40b  = data_q;
   assign word_type = type_q;
   assign idle_cnt  = idle_q;

endmodule

// File: tb/tb_single_edge_data_frame_tx_40b.sv
// Randomized bench for the 40-bit framer against a queue-based word model.
module tb_single_edge_data_frame_tx_40b;

   localparam int TW  = 4;
   localparam int ICW = 6;
   localparam logic [9:0]  K  = 10'b0011111010;
   localparam logic [9:0]  D  = 10'b1010101010;
   localparam logic [39:0] IW = {K, K, K, K};
   localparam logic [39:0] TWD = {K, D, K, D};
   localparam int M_WAIT = 0, M_TRAIN = 1, M_DATA = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            tick = 1'b0, locked = 1'b0, train_req = 1'b0, sym_valid = 1'b0;
   logic [9:0]      sym_in = '0;
   logic            sym_ready;
   logic [3:0]      slip = 4'd5;
   logic [39:0]     data_40b;
   logic [1:0]      word_type;
   logic [ICW-1:0]  idle_cnt;

   int n_chk = 0, n_bad = 0;

   // reference model
   int          mode = M_WAIT;
   int          left = 0;
   logic [9:0]  q[$];
   logic [39:0] e_data = '0, prev_w = '0, last_w = '0, last_out = '0;
   logic [1:0]  e_type = 2'd0;
   int          e_idle = 0;
   bit          last_s5 = 0;

   always #5 clk = ~clk;

   single_edge_data_frame_tx_40b #(.TRAIN_WORDS(TW), .IDLE_CNT_W(ICW)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .locked    (locked),
      .train_req (train_req),
      .sym_in    (sym_in),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
`ifdef TX_SLIP_EN
      .slip      (slip),
`endif
      .data_40b  (data_40b),
      .word_type (word_type),
      .idle_cnt  (idle_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] slipped(input logic [39:0] p, input logic [39:0] w, input int s);
      logic [39:0] r;
      if (s == 0 || s == 15) return w;
      for (int i = 0; i < 40; i++)
         r[i] = (i >= s) ? p[i - s] : w[40 - s + i];
      return r;
   endfunction

   task automatic model_reset();
      mode = M_WAIT; q.delete(); e_data = '0; e_type = 2'd0; e_idle = 0;
      prev_w = '0; last_s5 = 0;
   endtask

   task automatic cycle(input bit lk, input bit tk, input bit tr, input bit vl, input logic [9:0] sy);
      bit ev, rdy, acc, em;
      logic [39:0] w;
      int s;
      @(negedge clk);
      locked = lk; tick = tk; train_req = tr; sym_valid = vl; sym_in = sy;
      #1;
      ev  = lk & tk;
      rdy = (mode == M_DATA) && (q.size() < 4 || ev);
      chk("sym_ready", sym_ready, rdy);
      acc = vl & rdy;
      em  = 0;
      w   = '0;
      if (!lk) begin
         mode = M_WAIT; q.delete();
      end else if (mode == M_WAIT) begin
         mode = M_TRAIN; left = TW;
      end else if (mode == M_TRAIN) begin
         if (ev) begin
            em = 1; w = TWD; e_type = 2'd2;
            left--;
            if (left == 0) mode = M_DATA;
         end
      end else begin
         if (ev) begin
            em = 1;
            if (q.size() == 4) begin
               w = {q[0], q[1], q[2], q[3]}; q.delete(); e_type = 2'd1;
            end else begin
               w = IW; e_type = 2'd0;
               if (e_idle < (1 << ICW) - 1) e_idle++;
            end
         end
         if (acc) q.push_back(sy);
         if (tr) begin mode = M_TRAIN; left = TW; end
      end
`ifdef TX_SLIP_EN
      s = int'(slip);
`else
      s = 0;
`endif
      if (em) begin
         e_data = slipped(prev_w, w, s);
         prev_w = w;
      end
      @(posedge clk);
      #1;
      chk("data_40b", data_40b, e_data);
      chk("word_type", word_type, e_type);
      chk("idle_cnt", idle_cnt, e_idle);
`ifdef TX_SLIP_EN
      if (em) begin
         if (s == 5 && last_s5)
            chk("realign5", {last_out[4:0], data_40b[39:5]}, last_w);
         last_s5  = (s == 5);
         last_out = data_40b;
         last_w   = w;
      end
`endif
   endtask

   initial begin
      logic [9:0] s4 [4];
      bit lk, tk;
      #1;
      chk("rst_data", data_40b, 40'd0);
      chk("rst_type", word_type, 2'd0);
      chk("rst_idle", idle_cnt, 0);
      chk("rst_ready", sym_ready, 1'b0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      cycle(0, 1, 0, 1, 10'h3ff);

      // training with a tick every fourth clock
      for (int i = 0; i < 16; i++) cycle(1, (i % 4) == 3, 0, 1, 10'h155);
      chk("train_type", word_type, 2'd2);
      chk("train_word", data_40b, TWD);

      for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 1, 10'(i));
      cycle(1, 1, 0, 0, 0);
`ifndef TX_SLIP_EN
      chk("data_1234", data_40b, 40'h0040200C04);
`endif
      chk("data_type", word_type, 2'd1);

      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
      chk("idle3_cnt", idle_cnt, 3);
      chk("idle3_type", word_type, 2'd0);
      for (int i = 0; i < 70; i++) cycle(1, 1, 0, 0, 0);
      chk("idle_sat", idle_cnt, {ICW{1'b1}});

      // loss of lock flushes staged symbols
      cycle(1, 0, 0, 1, 10'h0aa);
      cycle(1, 0, 0, 1, 10'h0bb);
      cycle(0, 0, 0, 1, 10'h0cc);
      cycle(0, 0, 0, 1, 10'h0dd);
      for (int i = 0; i < 6; i++) cycle(1, i > 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) s4[i] = 10'($urandom);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, s4[i]);
      cycle(1, 1, 0, 0, 0);
`ifndef TX_SLIP_EN
      chk("relock_word", data_40b, {s4[0], s4[1], s4[2], s4[3]});
`endif

      // train request keeps three staged symbols
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, s4[3 - i]);
      cycle(1, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, 10'h111);
      cycle(1, 0, 0, 1, 10'h222);
      cycle(1, 1, 0, 0, 0);
`ifndef TX_SLIP_EN
      chk("treq_word", data_40b, {s4[3], s4[2], s4[1], 10'h222});
`endif

      // random traffic; lock only changes on non-tick cycles
      lk = 1;
      for (int i = 0; i < 600; i++) begin
         tk = ($urandom_range(2) == 0);
         if (!tk && $urandom_range(40) == 0) lk = !lk;
`ifdef TX_SLIP_EN
         if (i >= 300) slip = 4'($urandom);
`endif
         cycle(lk, tk, $urandom_range(50) == 0, $urandom_range(1), 10'($urandom));
      end

      // reset mid-word
      cycle(1, 0, 0, 1, 10'h001);
      cycle(1, 0, 0, 1, 10'h002);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", sym_ready, 1'b0);
      chk("mid_rst_data", data_40b, 40'd0);
      chk("mid_rst_idle", idle_cnt, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) cycle(1, i > 0, 0, $urandom_range(1), 10'($urandom));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
